// File: rtl/countdown_pkg.sv
// countdown_pkg: shared FSM encoding, digit width and preset-to-BCD helper
package countdown_pkg;
    typedef enum logic [1:0] {PAUSE = 2'd0, COUNT = 2'd1, DONE = 2'd2} fsm_t;
    localparam int BCD_W = 4;
    function automatic logic [2*BCD_W-1:0] to_bcd(input int sec);
        return {BCD_W'(sec / 10), BCD_W'(sec % 10)};
    endfunction
endpackage

// File: rtl/debounce_onepulse.sv
// debounce_onepulse: shift-register debouncer with a one-cycle registered press pulse
// clk, rst    : clock, asynchronous active-high reset
// pb_in       : raw button, active-high
// pb_pulse    : one-cycle pulse on each debounced rising edge
module debounce_onepulse #(
    parameter int DEBOUNCE_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_in,
    output logic pb_pulse
);
    logic [DEBOUNCE_LEN-1:0] sr;
    logic lvl, lvl_q;
    assign lvl = &sr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr       <= '0;
            lvl_q    <= 1'b0;
            pb_pulse <= 1'b0;
        end else begin
            sr       <= {sr[DEBOUNCE_LEN-2:0], pb_in};
            lvl_q    <= lvl;
            pb_pulse <= lvl & ~lvl_q;
        end
    end
endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: debounced start/pause button driving a BCD seconds countdown
// clk, rst            : clock, asynchronous active-high reset
// pb_sp               : raw start/pause/reload button
// state               : 1 while counting
// stop                : 1 once the count reached 00, until reload
// sec_tens, sec_ones  : BCD digits of remaining seconds
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int CLK_DIV      = 100_000_000,
    parameter int INIT_SEC     = 30,
    parameter int DEBOUNCE_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pb_sp,
    output logic             state,
    output logic             stop,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones
);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [2*BCD_W-1:0] INIT_BCD = to_bcd(INIT_SEC);
    fsm_t st, st_n;
    logic [PW-1:0] presc, presc_n;
    logic [BCD_W-1:0] tens, ones, tens_n, ones_n, dec_tens, dec_ones;
    logic press, tick, dec_zero;
    debounce_onepulse #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_db (
        .clk      (clk),
        .rst      (rst),
        .pb_in    (pb_sp),
        .pb_pulse (press)
    );
    assign tick     = (st == COUNT) && (presc == PW'(CLK_DIV - 1));
    assign dec_tens = (ones == '0) ? tens - BCD_W'(1) : tens;
    assign dec_ones = (ones == '0) ? BCD_W'(9) : ones - BCD_W'(1);
    assign dec_zero = (dec_tens == '0) && (dec_ones == '0);
    always_comb begin
        st_n    = st;
        presc_n = presc;
        tens_n  = tens;
        ones_n  = ones;
        case (st)
            PAUSE: st_n = press ? COUNT : PAUSE;
            COUNT: begin
                presc_n = tick ? '0 : presc + PW'(1);
                tens_n  = tick ? dec_tens : tens;
                ones_n  = tick ? dec_ones : ones;
                // reaching 00 wins over a simultaneous pause request
                st_n    = (tick && dec_zero) ? DONE : press ? PAUSE : COUNT;
            end
            DONE: begin
                if (press) begin
                    st_n            = PAUSE;
                    presc_n         = '0;
                    {tens_n, ones_n} = INIT_BCD;
                end
            end
            default: st_n = PAUSE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st           <= PAUSE;
            presc        <= '0;
            {tens, ones} <= INIT_BCD;
        end else begin
            st    <= st_n;
            presc <= presc_n;
            tens  <= tens_n;
            ones  <= ones_n;
        end
    end
    assign state    = (st == COUNT);
    assign stop     = (st == DONE);
    assign sec_tens = tens;
    assign sec_ones = ones;
endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Countdown controller that sits directly upstream of the LED display stage and drives its `state` and `stop` inputs. It debounces a start/pause push-button and counts a BCD seconds value down from a preset at a 1 Hz tick. It reports whether counting is active (`state`) and when the countdown has expired (`stop`). The BCD digits are also exported for the seven-segment stage.

## Interface
- `CLK_DIV`, 100_000_000: clock cycles per 1-second tick; must be ≥2.
- `INIT_SEC`, 30: preset seconds value, legal range 1..99.
- `DEBOUNCE_LEN`, 4: consecutive high samples required for a valid press; must be ≥2.

- `clk` input 1: system clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `pb_sp` input 1: raw start/pause/reload push-button, active-high, unsynchronised.
- `state` output 1: 1 while counting, 0 otherwise. Feeds LED `state`.
- `stop` output 1: 1 once the count has reached 00, held until reload. Feeds LED `stop`.
- `sec_tens` output 4: BCD tens digit of remaining seconds.
- `sec_ones` output 4: BCD ones digit of remaining seconds.

## Operation
- Reset values:
  - FSM = PAUSE; `state` = 0; `stop` = 0.
  - `sec_tens`/`sec_ones` = BCD of `INIT_SEC`.
  - Prescaler = 0; debounce shift register = 0.
- Button path:
  - `pb_sp` shifts into a `DEBOUNCE_LEN`-bit register every cycle.
  - The debounced level is the AND of all bits.
  - `press` is a one-cycle registered pulse on the rising edge of the debounced level.
  - Holding the button produces exactly one pulse. Glitches shorter than `DEBOUNCE_LEN` cycles produce none.
- FSM states and transitions:
  - PAUSE (`state` = 0, `stop` = 0): `press` → COUNT. The prescaler is not cleared, so a resumed count keeps its partial second.
  - COUNT (`state` = 1, `stop` = 0):
    - The prescaler increments each cycle. At `CLK_DIV`-1 it wraps to 0 and generates `tick`.
    - `tick` decrements the BCD value. If ones = 0, ones becomes 9 and tens decrements; otherwise ones decrements.
    - A decrement that produces 00 → DONE.
    - `press` → PAUSE.
  - DONE (`state` = 0, `stop` = 1):
    - Digits hold at 00 and the prescaler holds.
    - `press` reloads `INIT_SEC`, clears the prescaler and goes to PAUSE.
- Simultaneous `press` and `tick` in COUNT:
  - The decrement is applied.
  - If the new value is 00 the next state is DONE (DONE has priority); otherwise it is PAUSE.
- Digit range: BCD never leaves 0..9 per digit and never underflows below 00.
- `state` and `stop` are never both 1.

## Timing
- All outputs are registered and decoded directly from FSM and digit flops. There is no combinational path from `pb_sp` to any output.
- Press latency: let edge E be the first rising edge that samples `pb_sp` high.
  - The shift register is full after edge E+`DEBOUNCE_LEN`-1.
  - `press` is high during the cycle after edge E+`DEBOUNCE_LEN`.
  - FSM outputs change at edge E+`DEBOUNCE_LEN`+1.
- Tick latency: the digits update on the same edge at which the prescaler wraps to 0. From a freshly cleared prescaler, the first decrement occurs `CLK_DIV` cycles after entering COUNT.
- Reset mid-operation: asserting `rst` forces all outputs to their reset values immediately (asynchronously). Operation resumes from PAUSE on the first edge after deassertion.

## Structure
- Shared package `countdown_pkg` contains:
  - FSM encoding: PAUSE = 2'd0, COUNT = 2'd1, DONE = 2'd2.
  - `BCD_W` = 4.
  - A function converting `INIT_SEC` to a tens/ones BCD pair.
- Sub-module `debounce_onepulse` (ports: `clk`, `rst`, `pb_in`, `pb_pulse`; parameter `DEBOUNCE_LEN`) holds the shift register and edge detector.
- The top level holds the prescaler (width $clog2(`CLK_DIV`)), the FSM and the BCD counter.

## Test plan
Bench parameters: `CLK_DIV`=4, `INIT_SEC`=12, `DEBOUNCE_LEN`=3.
- Reset → `state`=0, `stop`=0, digits 1/2. Outputs stay unchanged for 50 cycles with `pb_sp`=0.
- Hold `pb_sp` high 10 cycles → `state` rises at edge E+4 (single transition).
  - Subsequent digits step 11, 10, 09 at 4-cycle intervals; the 10→09 step checks the borrow.
- Press during COUNT at prescaler=2 → `state`=0 and digits hold for 40 cycles.
  - Press again → first decrement 2 cycles after `state` returns to 1.
- Let the count run to 00 → `stop`=1, `state`=0, digits 0/0; no change over 20 further cycles.
  - Press → digits 1/2, `stop`=0, `state`=0.
- `pb_sp` pulses of 1 and 2 cycles, separated by lows → no `press`, no output change in any state.
- Assert `rst` asynchronously mid-cycle during COUNT at digits 0/7 → outputs return to 0, 0, 1/2 before the next clock edge.
- Force `press` and `tick` together at digits 0/1 → DONE, `stop`=1, digits 0/0.
